// File: rtl/microroc_ram_readout.sv
// MICROROC ASIC RAM readout: synchronises the ASIC serial outputs, assembles MSB-first words and pushes them to a FIFO.
// Optional wait-for-EndReadout timeout enabled by defining RAM_READOUT_TIMEOUT_EN.
module microroc_ram_readout #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000,
    parameter int          WORD_WIDTH     = 16
) (
    input  logic                  Clk,
    input  logic                  reset_n,
    input  logic                  ReadoutStart,
    input  logic                  ReadoutClockEnable,
    output logic                  START_READOUT,
    input  logic                  END_READOUT,
    input  logic                  DOUTB,
    input  logic                  TRANSMITONB,
    output logic [WORD_WIDTH-1:0] FifoData,
    output logic                  FifoWriteEn,
    input  logic                  FifoFull,
    output logic                  ReadoutBusy,
    output logic                  ReadoutDone,
    output logic [15:0]           WordCount,
    output logic                  OverflowFlag,
    output logic                  TimeoutFlag
);

    localparam int CW = (WORD_WIDTH > 2) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_WIDTH - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] FLUSH = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    if (WORD_WIDTH < 2 || TIMEOUT_CYCLES == 24'd0) begin : gBadParams
        $error("microroc_ram_readout: WORD_WIDTH must be >= 2 and TIMEOUT_CYCLES nonzero");
    end

    logic [2:0]            state;
    logic [2:0]            stateNext;
    logic [1:0]            endSync;
    logic [1:0]            doutSync;
    logic [1:0]            txSync;
    logic                  endPrev;
    logic                  endRise;
    logic [WORD_WIDTH-1:0] shiftReg;
    logic [WORD_WIDTH-1:0] shiftNext;
    logic [WORD_WIDTH-1:0] bitIn;
    logic [WORD_WIDTH-1:0] flushWord;
    logic [WORD_WIDTH-1:0] wordOut;
    logic [CW-1:0]         bitCnt;
    logic [CW-1:0]         bitCntNext;
    logic                  wordDone;
    logic                  clearRun;
    logic                  timeoutHit;
    int                    padBits;

    assign endRise = endSync[1] & ~endPrev;

    // Next-state, shift register and word-completion decode
    always_comb begin
        stateNext  = state;
        shiftNext  = shiftReg;
        bitCntNext = bitCnt;
        wordDone   = 1'b0;
        wordOut    = {WORD_WIDTH{1'b0}};
        clearRun   = 1'b0;
        bitIn      = {shiftReg[WORD_WIDTH-2:0], ~doutSync[1]};
        padBits    = WORD_WIDTH - int'(bitCnt);
        flushWord  = shiftReg << padBits;
        case (state)
            IDLE: begin
                if (ReadoutStart) begin
                    stateNext  = START;
                    shiftNext  = {WORD_WIDTH{1'b0}};
                    bitCntNext = {CW{1'b0}};
                    clearRun   = 1'b1;
                end else begin
                    stateNext  = IDLE;
                end
            end
            START: begin
                if (timeoutHit) begin
                    stateNext = FLUSH;
                end else if (ReadoutClockEnable) begin
                    stateNext = SHIFT;
                end else begin
                    stateNext = START;
                end
            end
            SHIFT: begin
                if (ReadoutClockEnable && !txSync[1]) begin
                    if (bitCnt == LAST_BIT) begin
                        wordDone   = 1'b1;
                        wordOut    = bitIn;
                        bitCntNext = {CW{1'b0}};
                        shiftNext  = {WORD_WIDTH{1'b0}};
                    end else begin
                        bitCntNext = bitCnt + CW'(1);
                        shiftNext  = bitIn;
                    end
                end else begin
                    bitCntNext = bitCnt;
                    shiftNext  = shiftReg;
                end
                // A word completing alongside END_READOUT is still pushed above
                if (endRise || timeoutHit) begin
                    stateNext = FLUSH;
                end else begin
                    stateNext = SHIFT;
                end
            end
            FLUSH: begin
                if (bitCnt != {CW{1'b0}}) begin
                    wordDone = 1'b1;
                    wordOut  = flushWord;
                end else begin
                    wordDone = 1'b0;
                end
                bitCntNext = {CW{1'b0}};
                shiftNext  = {WORD_WIDTH{1'b0}};
                stateNext  = DONE;
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State, synchronisers and registered outputs
    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            endSync       <= 2'b00;
            doutSync      <= 2'b11;
            txSync        <= 2'b11;
            endPrev       <= 1'b0;
            shiftReg      <= {WORD_WIDTH{1'b0}};
            bitCnt        <= {CW{1'b0}};
            START_READOUT <= 1'b0;
            ReadoutBusy   <= 1'b0;
            ReadoutDone   <= 1'b0;
            FifoWriteEn   <= 1'b0;
            FifoData      <= {WORD_WIDTH{1'b0}};
            WordCount     <= 16'd0;
            OverflowFlag  <= 1'b0;
        end else begin
            endSync       <= {endSync[0], END_READOUT};
            doutSync      <= {doutSync[0], DOUTB};
            txSync        <= {txSync[0], TRANSMITONB};
            endPrev       <= endSync[1];
            state         <= stateNext;
            shiftReg      <= shiftNext;
            bitCnt        <= bitCntNext;
            START_READOUT <= (stateNext == START) || (stateNext == SHIFT) || (stateNext == FLUSH);
            ReadoutBusy   <= (stateNext != IDLE);
            ReadoutDone   <= (stateNext == DONE);
            FifoWriteEn   <= wordDone & ~FifoFull;
            if (wordDone && !FifoFull) begin
                FifoData <= wordOut;
            end else begin
                FifoData <= FifoData;
            end
            if (clearRun) begin
                WordCount <= 16'd0;
            end else if (wordDone && !FifoFull && WordCount != 16'hFFFF) begin
                WordCount <= WordCount + 16'd1;
            end else begin
                WordCount <= WordCount;
            end
            if (clearRun) begin
                OverflowFlag <= 1'b0;
            end else if (wordDone && FifoFull) begin
                OverflowFlag <= 1'b1;
            end else begin
                OverflowFlag <= OverflowFlag;
            end
        end
    end

`ifdef RAM_READOUT_TIMEOUT_EN
    logic [23:0] timeoutCnt;
    logic        timeoutSet;

    assign timeoutHit = (timeoutCnt == TIMEOUT_CYCLES - 24'd1);
    // END_READOUT wins over a simultaneous timeout, so no flag in that case
    assign timeoutSet = timeoutHit && ((state == START) || (state == SHIFT && !endRise));

    // Wait-for-EndReadout cycle counter and sticky timeout flag
    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            timeoutCnt  <= 24'd0;
            TimeoutFlag <= 1'b0;
        end else begin
            if (state == START || state == SHIFT) begin
                timeoutCnt <= timeoutCnt + 24'd1;
            end else begin
                timeoutCnt <= 24'd0;
            end
            if (clearRun) begin
                TimeoutFlag <= 1'b0;
            end else if (timeoutSet) begin
                TimeoutFlag <= 1'b1;
            end else begin
                TimeoutFlag <= TimeoutFlag;
            end
        end
    end
`else
    assign timeoutHit  = 1'b0;
    assign TimeoutFlag = 1'b0;
`endif

endmodule
